// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, request-to-send, device-clocked frame, ack).
// Optional single retry on failure when PS2_HOST_TX_RETRY_EN is defined.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int SYNC_STAGES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       timeout
);
    localparam int CW = $clog2((TIMEOUT_CYCLES > INHIBIT_CYCLES ? TIMEOUT_CYCLES : INHIBIT_CYCLES) + 1);

    typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_clk_sync, r_data_sync;
    logic                   r_clk_prev;
    logic [7:0]             r_byte;
    logic                   r_par;
    logic [3:0]             r_bit;
    logic [CW-1:0]          r_cnt;
    logic                   r_clk_oe, r_data_oe, r_ready, r_done, r_ack_ok, r_ack, r_timeout;
    logic                   w_clk_s, w_data_s, w_fall, w_live, w_tmo, w_idle_lines, w_fail, w_ok, w_retry;
    logic [9:0]             w_frame;

    assign w_clk_s      = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s     = r_data_sync[SYNC_STAGES-1];
    assign w_fall       = r_clk_prev & ~w_clk_s;
    assign w_live       = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
    assign w_tmo        = w_live && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_idle_lines = (r_state == S_WAIT_IDLE) && w_clk_s && w_data_s;
    assign w_fail       = w_tmo || (w_idle_lines && !r_ack);
    assign w_ok         = !w_tmo && w_idle_lines && r_ack;
    // Bits shifted out on falling edges 1..10: data LSB first, parity, stop.
    assign w_frame      = {1'b1, r_par, r_byte};

`ifdef PS2_HOST_TX_RETRY_EN
    logic r_retry;
    assign w_retry = ~r_retry;
`else
    assign w_retry = 1'b0;
`endif

    assign tx_ready    = r_ready;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign ack_ok      = r_ack_ok;
    assign timeout     = r_timeout;

    // Sync flops reset high so an idle bus never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data_in};
            r_clk_prev  <= w_clk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_byte    <= '0;
            r_par     <= 1'b0;
            r_bit     <= '0;
            r_cnt     <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_ack_ok  <= 1'b0;
            r_ack     <= 1'b0;
            r_timeout <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            r_retry   <= 1'b0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_ack_ok  <= 1'b0;
            r_timeout <= 1'b0;
            if (w_fail && w_retry) begin
`ifdef PS2_HOST_TX_RETRY_EN
                r_retry   <= 1'b1;
`endif
                r_state   <= S_INHIBIT;
                r_clk_oe  <= 1'b1;
                r_data_oe <= 1'b0;
                r_cnt     <= '0;
            end else if (w_fail || w_ok) begin
                r_state   <= S_IDLE;
                r_clk_oe  <= 1'b0;
                r_data_oe <= 1'b0;
                r_ready   <= 1'b1;
                r_done    <= !w_tmo;
                r_ack_ok  <= w_ok;
                r_timeout <= w_tmo;
            end else begin
                case (r_state)
                    S_IDLE: if (tx_valid && r_ready) begin
                        r_byte    <= tx_data;
                        r_par     <= ~^tx_data;
                        r_ready   <= 1'b0;
                        r_state   <= S_INHIBIT;
                        r_clk_oe  <= 1'b1;
                        r_data_oe <= 1'b0;
                        r_cnt     <= '0;
`ifdef PS2_HOST_TX_RETRY_EN
                        r_retry   <= 1'b0;
`endif
                    end
                    S_INHIBIT: begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(INHIBIT_CYCLES - 1)) begin
                            r_state   <= S_START;
                            r_data_oe <= 1'b1;
                        end
                    end
                    S_START: begin
                        r_state  <= S_SEND;
                        r_clk_oe <= 1'b0;
                        r_bit    <= '0;
                        r_cnt    <= '0;
                    end
                    S_SEND: begin
                        r_cnt <= r_cnt + CW'(1);
                        if (w_fall && r_bit == 4'd10) begin
                            r_ack   <= ~w_data_s;
                            r_state <= S_ACK;
                        end else if (w_fall) begin
                            r_data_oe <= ~w_frame[r_bit];
                            r_bit     <= r_bit + 4'd1;
                        end
                    end
                    S_ACK: begin
                        r_cnt   <= r_cnt + CW'(1);
                        r_state <= S_WAIT_IDLE;
                    end
                    default: r_cnt <= r_cnt + CW'(1);
                endcase
            end
        end
    end
endmodule
